// File: rtl/alu_issue_stage.sv
// ============================================================================
// alu_issue_stage : decode/issue and result capture around a 16-bit ALU
// Optional macro ALU_ISSUE_SAT_EN saturates ADD/SUB results on overflow.
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage #(
  parameter int          REG_ADDR_W = 4,
  parameter logic [2:0]  FLAGS_RST  = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_instr,
  output logic [REG_ADDR_W-1:0] ra_addr,
  output logic [REG_ADDR_W-1:0] rb_addr,
  input  logic [15:0]           ra_data,
  input  logic [15:0]           rb_data,
  output logic [15:0]           alu_a,
  output logic [15:0]           alu_b,
  output logic [4:0]            alu_ctrl,
  input  logic [15:0]           alu_out,
  input  logic                  alu_ovfl,
  input  logic                  flush,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [15:0]           wb_data,
  output logic                  illegal,
  output logic [2:0]            flags
);

  localparam logic [4:0] CTRL_NOP = 5'h1F;

  logic [3:0]  op;
  logic [4:0]  dec_ctrl;
  logic [15:0] dec_a;
  logic [15:0] dec_b;
  logic        dec_ill;
  logic        dec_nv;

  logic                  v1_q, v2_q;
  logic [15:0]           alu_a_q, alu_b_q;
  logic [4:0]            alu_ctrl_q;
  logic [REG_ADDR_W-1:0] rd1_q, wb_addr_q;
  logic                  ill1_q, nv1_q, ill2_q;
  logic [15:0]           wb_data_q, wb_data_d;
  logic                  z_q, n_q, v_q, z_d, n_d, v_d;
  logic                  adv2, adv1, accept;

  assign op      = in_instr[15:12];
  assign ra_addr = (op == 4'h8 || op == 4'h9) ? REG_ADDR_W'(in_instr[11:8])
                                              : REG_ADDR_W'(in_instr[7:4]);
  assign rb_addr = REG_ADDR_W'(in_instr[3:0]);

  always_comb begin
    dec_ctrl = CTRL_NOP;
    dec_a    = 16'h0000;
    dec_b    = 16'h0000;
    dec_ill  = 1'b1;
    dec_nv   = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        dec_ctrl = {1'b0, op};
        dec_a    = ra_data;
        dec_b    = rb_data;
        dec_ill  = 1'b0;
        dec_nv   = (op == 4'h0) || (op == 4'h1);
      end
      4'h8, 4'h9: begin
        dec_ctrl = {1'b0, op};
        dec_a    = ra_data;
        dec_b    = {8'h00, in_instr[7:0]};
        dec_ill  = 1'b0;
      end
      4'hA, 4'hB: begin
        dec_ctrl = {1'b0, op};
        dec_a    = ra_data;
        dec_b    = {{12{in_instr[3]}}, in_instr[3:0]};
        dec_ill  = 1'b0;
      end
      default: ;
    endcase
  end

  // S2 drains when empty or consumed; S1 may refill in the same cycle it moves.
  assign adv2     = !v2_q || wb_ready;
  assign adv1     = v1_q && adv2;
  assign in_ready = !v1_q || adv2;
  assign accept   = in_valid && in_ready;

`ifdef ALU_ISSUE_SAT_EN
  assign wb_data_d = ill1_q                ? 16'h0000 :
                     (nv1_q && alu_ovfl)   ? (alu_out[15] ? 16'h7FFF : 16'h8000) :
                                             alu_out;
`else
  assign wb_data_d = ill1_q ? 16'h0000 : alu_out;
`endif

  assign z_d = ill1_q ? z_q : (alu_out == 16'h0000);
  assign n_d = nv1_q  ? alu_out[15] : n_q;
  assign v_d = nv1_q  ? alu_ovfl    : v_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      alu_a_q    <= 16'h0000;
      alu_b_q    <= 16'h0000;
      alu_ctrl_q <= 5'h00;
      rd1_q      <= '0;
      ill1_q     <= 1'b0;
      nv1_q      <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= 16'h0000;
      ill2_q     <= 1'b0;
      {z_q, n_q, v_q} <= FLAGS_RST;
    end else if (flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      if (adv2) begin
        v2_q <= v1_q;
      end
      if (adv1) begin
        wb_addr_q <= rd1_q;
        wb_data_q <= wb_data_d;
        ill2_q    <= ill1_q;
        z_q       <= z_d;
        n_q       <= n_d;
        v_q       <= v_d;
      end
      if (in_ready) begin
        v1_q <= in_valid;
      end
      if (accept) begin
        alu_a_q    <= dec_a;
        alu_b_q    <= dec_b;
        alu_ctrl_q <= dec_ctrl;
        rd1_q      <= REG_ADDR_W'(in_instr[11:8]);
        ill1_q     <= dec_ill;
        nv1_q      <= dec_nv;
      end
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_ctrl = alu_ctrl_q;
  assign wb_valid = v2_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign illegal  = ill2_q;
  assign flags    = {z_q, n_q, v_q};

endmodule

`default_nettype wire
